mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 145 ++++++++++++++
 tb/tb_mem_stage.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// MEM pipeline stage: byte-addressed little-endian data memory with a
// configurable wait-state counter, MEM/WB pipeline register and branch
// resolution outputs.
`timescale 1ns/1ps

module mem_stage #(
  parameter int DEPTH_DW = 16,  // memory depth in 64-bit doublewords (power of two, >= 2)
  parameter int LAT      = 1    // extra wait cycles per memory access
) (
  input  logic        clk,
  input  logic        reset,          // asynchronous, active-low
  input  logic [63:0] Result_inp,
  input  logic [63:0] data_inp,
  input  logic [4:0]  rd_inp,
  input  logic [2:0]  funct3_inp,
  input  logic        MemRead_inp,
  input  logic        MemWrite_inp,
  input  logic        MemtoReg_inp,
  input  logic        RegWrite_inp,
  input  logic        Branch_inp,
  input  logic        ZERO_inp,
  input  logic [63:0] PC_In,
  output logic        PCSrc_out,
  output logic [63:0] PC_target_out,
  output logic        stall_out,
  output logic [63:0] ReadData_out,
  output logic [63:0] Result_out,
  output logic [4:0]  rd_out,
  output logic        MemtoReg_out,
  output logic        RegWrite_out,
  output logic        misalign_out
);

  localparam int BYTES  = DEPTH_DW * 8;
  localparam int ADDR_W = $clog2(BYTES);
  localparam int CNT_W  = (LAT > 0) ? $clog2(LAT + 1) : 1;
  localparam logic [CNT_W-1:0] LAT_V = CNT_W'(LAT);

  logic [CNT_W-1:0]  cnt;
  logic              mem_op;
  logic              is_load;
  logic              is_store;
  logic              done;
  logic              misalign;
  logic [ADDR_W-1:0] idx;
  logic [7:0]        lanes;     // byte lanes touched, relative to idx
  logic [63:0]       raw;       // 8 bytes starting at idx
  logic [63:0]       load_val;

  logic [7:0] mem [BYTES];

  // Branch resolution is purely combinational and ignores stall state
  assign PCSrc_out     = Branch_inp & ZERO_inp;
  assign PC_target_out = PC_In;

  // Decode access type, size, alignment and wait-state status
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    mem_op    = MemRead_inp | MemWrite_inp;
    is_store  = MemWrite_inp;                 // read+write together acts as a store
    is_load   = MemRead_inp & ~MemWrite_inp;
    stall_out = mem_op && (cnt != LAT_V);
    done      = mem_op && (cnt == LAT_V);
    idx       = Result_inp[ADDR_W-1:0];       // upper address bits wrap around
    misalign  = 1'b0;
    lanes     = 8'h00;
    unique case (funct3_inp[1:0])
      2'b00: begin lanes = 8'h01; misalign = 1'b0;             end
      2'b01: begin lanes = 8'h03; misalign = idx[0];           end
      2'b10: begin lanes = 8'h0f; misalign = (idx[1:0] != 0);  end
      default: begin lanes = 8'hff; misalign = (idx[2:0] != 0); end
    endcase
  end

  // Gather the addressed bytes and apply sign or zero extension
  always_comb begin
    raw = '0;
    for (int i = 0; i < 8; i++) begin
      raw[8*i +: 8] = mem[idx + ADDR_W'(i)];
    end
    unique case (funct3_inp)
      3'b000:  load_val = {{56{raw[7]}},  raw[7:0]};
      3'b001:  load_val = {{48{raw[15]}}, raw[15:0]};
      3'b010:  load_val = {{32{raw[31]}}, raw[31:0]};
      3'b100:  load_val = {56'd0, raw[7:0]};
      3'b101:  load_val = {48'd0, raw[15:0]};
      3'b110:  load_val = {32'd0, raw[31:0]};
      default: load_val = raw;                // 011 and 111: full doubleword
    endcase
  end

  // Wait-state counter: advances while stalling, returns to 0 otherwise
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (!reset) cnt <= '0;
    else if (stall_out) cnt <= cnt + CNT_W'(1);
    else cnt <= '0;
  end

  // Store: write only the addressed, aligned bytes on the completion edge
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset branch; its contents must survive reset,
    // and a reset arm would keep it from mapping onto a RAM macro.
    if (done && is_store && !misalign && reset) begin
      for (int i = 0; i < 8; i++) begin
        if (lanes[i]) mem[idx + ADDR_W'(i)] <= data_inp[8*i +: 8];
      end
    end
  end

  // MEM/WB register: bubble while stalling, result on completion or non-mem op
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ReadData_out <= '0;
      Result_out   <= '0;
      rd_out       <= '0;
      MemtoReg_out <= 1'b0;
      RegWrite_out <= 1'b0;
      misalign_out <= 1'b0;
    end else if (stall_out) begin
      ReadData_out <= '0;
      Result_out   <= '0;
      rd_out       <= '0;
      MemtoReg_out <= 1'b0;
      RegWrite_out <= 1'b0;
      misalign_out <= 1'b0;
    end else begin
      Result_out   <= Result_inp;
      rd_out       <= rd_inp;
      MemtoReg_out <= MemtoReg_inp;
      if (mem_op) begin
        RegWrite_out <= RegWrite_inp & ~misalign;
        misalign_out <= misalign;
        ReadData_out <= (is_load && !misalign) ? load_val : 64'd0;
      end else begin
        RegWrite_out <= RegWrite_inp;
        misalign_out <= 1'b0;
        ReadData_out <= 64'd0;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: instruction-level reference model with
// a byte-array memory, a per-cycle compare process and pinned literal cases.
`timescale 1ns/1ps

module tb_mem_stage;

  localparam int DEPTH_DW = 16;
  localparam int LAT      = 1;
  localparam int MB       = DEPTH_DW * 8;

  logic        clk;
  logic        reset;
  logic [63:0] Result_inp, data_inp, PC_In;
  logic [4:0]  rd_inp;
  logic [2:0]  funct3_inp;
  logic        MemRead_inp, MemWrite_inp, MemtoReg_inp, RegWrite_inp, Branch_inp, ZERO_inp;
  logic        PCSrc_out, stall_out, MemtoReg_out, RegWrite_out, misalign_out;
  logic [63:0] PC_target_out, ReadData_out, Result_out;
  logic [4:0]  rd_out;

  mem_stage #(.DEPTH_DW(DEPTH_DW), .LAT(LAT)) dut (
    .clk(clk), .reset(reset),
    .Result_inp(Result_inp), .data_inp(data_inp), .rd_inp(rd_inp), .funct3_inp(funct3_inp),
    .MemRead_inp(MemRead_inp), .MemWrite_inp(MemWrite_inp), .MemtoReg_inp(MemtoReg_inp),
    .RegWrite_inp(RegWrite_inp), .Branch_inp(Branch_inp), .ZERO_inp(ZERO_inp), .PC_In(PC_In),
    .PCSrc_out(PCSrc_out), .PC_target_out(PC_target_out), .stall_out(stall_out),
    .ReadData_out(ReadData_out), .Result_out(Result_out), .rd_out(rd_out),
    .MemtoReg_out(MemtoReg_out), .RegWrite_out(RegWrite_out), .misalign_out(misalign_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] addr, data, pc;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic        mr, mw, m2r, rw, br, z;
  } instr_t;

  typedef struct packed {
    logic [63:0] rdata, result;
    logic [4:0]  rd;
    logic        m2r, rw, mis;
  } wb_t;

  int errors = 0;
  int checks = 0;

  logic [7:0]  model_mem [MB];
  wb_t         exp_wb, next_wb;
  logic        exp_stall, exp_pcsrc;
  logic [63:0] exp_pct;
  logic        chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h expected 0x%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int nbytes(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic [63:0] model_load(input logic [63:0] a, input logic [2:0] f3);
    int n = nbytes(f3);
    int base = int'(a % 64'(MB));
    logic [63:0] v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = model_mem[(base + i) % MB];
    if (!f3[2] && n < 8 && v[8*n-1]) v = v | (~64'd0 << (8*n));
    return v;
  endfunction

  // Execute one instruction against the model; updates model memory on stores
  task automatic model_exec(input instr_t t, output wb_t r);
    int n, base;
    logic mis;
    r = '0;
    r.result = t.addr;
    r.rd     = t.rd;
    r.m2r    = t.m2r;
    r.rw     = t.rw;
    if (t.mr || t.mw) begin
      n    = nbytes(t.f3);
      base = int'(t.addr % 64'(MB));
      mis  = (t.addr % 64'(n)) != 0;
      r.mis = mis;
      if (mis) r.rw = 1'b0;
      else if (t.mw) begin
        for (int i = 0; i < n; i++) model_mem[(base + i) % MB] = t.data[8*i +: 8];
      end else r.rdata = model_load(t.addr, t.f3);
    end
  endtask

  task automatic apply(input instr_t t);
    Result_inp   = t.addr;  data_inp     = t.data;  PC_In        = t.pc;
    rd_inp       = t.rd;    funct3_inp   = t.f3;
    MemRead_inp  = t.mr;    MemWrite_inp = t.mw;    MemtoReg_inp = t.m2r;
    RegWrite_inp = t.rw;    Branch_inp   = t.br;    ZERO_inp     = t.z;
  endtask

  // Hold an instruction for its full occupancy, publishing expectations per cycle
  task automatic issue(input instr_t t);
    int waits = (t.mr || t.mw) ? LAT : 0;
    for (int k = 0; k <= waits; k++) begin
      @(negedge clk);
      apply(t);
      exp_wb    = next_wb;
      exp_stall = (k < waits);
      exp_pcsrc = t.br & t.z;
      exp_pct   = t.pc;
      if (k < waits) next_wb = '0;
      else model_exec(t, next_wb);
    end
  endtask

  // Issue and pin the load result / flags with hand-computed literals
  task automatic issue_lit(input instr_t t, input string name, input logic [63:0] rdata,
                           input logic rw, input logic mis);
    issue(t);
    @(posedge clk); #1;
    check({name, "_rdata"}, ReadData_out, rdata);
    check({name, "_regwrite"}, 64'(RegWrite_out), 64'(rw));
    check({name, "_misalign"}, 64'(misalign_out), 64'(mis));
  endtask

  function automatic instr_t mk(input logic mr, input logic mw, input logic [2:0] f3,
                                input logic [63:0] addr, input logic [63:0] data);
    instr_t t = '0;
    t.mr = mr; t.mw = mw; t.f3 = f3; t.addr = addr; t.data = data;
    t.rd = 5'd7; t.rw = mr & ~mw; t.m2r = mr & ~mw;
    return t;
  endfunction

  // Per-cycle comparison of every DUT output against the model
  always @(negedge clk) begin
    #1;
    if (chk_en) begin
      check("stall", 64'(stall_out), 64'(exp_stall));
      check("pcsrc", 64'(PCSrc_out), 64'(exp_pcsrc));
      check("pc_target", PC_target_out, exp_pct);
      check("read_data", ReadData_out, exp_wb.rdata);
      check("result", Result_out, exp_wb.result);
      check("rd", 64'(rd_out), 64'(exp_wb.rd));
      check("memtoreg", 64'(MemtoReg_out), 64'(exp_wb.m2r));
      check("regwrite", 64'(RegWrite_out), 64'(exp_wb.rw));
      check("misalign", 64'(misalign_out), 64'(exp_wb.mis));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    instr_t t;
    instr_t nop;
    int typ, n;

    nop = '0;
    apply(nop);
    exp_wb = '0; next_wb = '0; exp_stall = 1'b0; exp_pcsrc = 1'b0; exp_pct = '0;

    // Reset state
    reset = 1'b0;
    #2;
    check("rst_result", Result_out, 64'd0);
    check("rst_rdata", ReadData_out, 64'd0);
    check("rst_regwrite", 64'(RegWrite_out), 64'd0);
    check("rst_stall_idle", 64'(stall_out), 64'd0);
    MemRead_inp = 1'b1;
    #1;
    check("rst_stall_memop", 64'(stall_out), 64'd1);
    MemRead_inp = 1'b0;
    #9;
    reset = 1'b1;
    chk_en = 1'b1;

    // Initialise every doubleword so the model memory is fully known
    for (int i = 0; i < DEPTH_DW; i++)
      issue(mk(1'b0, 1'b1, 3'b011, 64'(8*i), {32'($urandom), 32'($urandom)}));

    // Doubleword store then load
    issue(mk(1'b0, 1'b1, 3'b011, 64'h10, 64'h1122334455667788));
    issue_lit(mk(1'b1, 1'b0, 3'b011, 64'h10, 64'd0), "ld_10", 64'h1122334455667788, 1'b1, 1'b0);
    issue_lit(mk(1'b1, 1'b0, 3'b000, 64'h17, 64'd0), "lb_17", 64'h11, 1'b1, 1'b0);
    issue(mk(1'b0, 1'b1, 3'b000, 64'h10, 64'hF0));
    issue_lit(mk(1'b1, 1'b0, 3'b000, 64'h10, 64'd0), "lb_10", 64'hFFFFFFFFFFFFFFF0, 1'b1, 1'b0);
    issue_lit(mk(1'b1, 1'b0, 3'b100, 64'h10, 64'd0), "lbu_10", 64'hF0, 1'b1, 1'b0);

    // Misaligned accesses
    issue_lit(mk(1'b1, 1'b0, 3'b010, 64'h12, 64'd0), "lw_12", 64'd0, 1'b0, 1'b1);
    issue(mk(1'b0, 1'b1, 3'b010, 64'h12, 64'hDEADBEEF));
    issue_lit(mk(1'b1, 1'b0, 3'b011, 64'h10, 64'd0), "ld_10_after_sw", 64'h11223344556677F0, 1'b1, 1'b0);

    // Address wrap-around
    issue(mk(1'b0, 1'b1, 3'b011, 64'h80, 64'hAA));
    issue_lit(mk(1'b1, 1'b0, 3'b011, 64'h00, 64'd0), "ld_wrap", 64'hAA, 1'b1, 1'b0);

    // Branch outputs
    t = nop; t.br = 1'b1; t.z = 1'b1; t.pc = 64'h40;
    issue(t);
    #2;
    check("br_taken", 64'(PCSrc_out), 64'd1);
    check("br_target", PC_target_out, 64'h40);
    t.z = 1'b0;
    issue(t);
    #2;
    check("br_not_taken", 64'(PCSrc_out), 64'd0);

    // Reset during the wait cycle of a store abandons the write
    issue(mk(1'b0, 1'b1, 3'b011, 64'h20, 64'h0123456789ABCDEF));
    t = nop; t.addr = 64'h55; t.rd = 5'd3; t.rw = 1'b1;
    issue(t);
    t = mk(1'b0, 1'b1, 3'b011, 64'h20, 64'hFFFF0000FFFF0000);
    @(negedge clk);
    apply(t);
    exp_wb = next_wb; exp_stall = 1'b1; exp_pcsrc = 1'b0; exp_pct = '0;
    #3;
    chk_en = 1'b0;
    reset  = 1'b0;
    #1;
    check("rstw_result", Result_out, 64'd0);
    check("rstw_rd", 64'(rd_out), 64'd0);
    check("rstw_regwrite", 64'(RegWrite_out), 64'd0);
    check("rstw_stall", 64'(stall_out), 64'd1);
    @(posedge clk);
    #2;
    reset   = 1'b1;
    next_wb = '0;
    chk_en  = 1'b1;
    issue(nop);
    issue_lit(mk(1'b1, 1'b0, 3'b011, 64'h20, 64'd0), "ld_after_rst", 64'h0123456789ABCDEF, 1'b1, 1'b0);

    // Randomised instruction stream
    for (int i = 0; i < 400; i++) begin
      t = '0;
      typ = int'($urandom_range(0, 3));
      t.f3   = 3'($urandom);
      t.addr = {32'($urandom), 32'($urandom)};
      t.data = {32'($urandom), 32'($urandom)};
      t.pc   = {32'($urandom), 32'($urandom)};
      t.rd   = 5'($urandom);
      t.m2r  = 1'($urandom);
      t.rw   = 1'($urandom);
      t.br   = 1'($urandom);
      t.z    = 1'($urandom);
      n = nbytes(t.f3);
      if ($urandom_range(0, 3) != 0) t.addr = t.addr & ~64'(n - 1);
      t.mr = (typ == 1) || (typ == 3);
      t.mw = (typ == 2) || (typ == 3);
      issue(t);
    end
    issue(nop);
    @(negedge clk);
    exp_wb = next_wb;
    exp_stall = 1'b0; exp_pcsrc = 1'b0; exp_pct = '0;
    #2;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
